// File: rtl/dcache_axi_wbridge.sv
// Write-back bridge: turns one accepted cacheline into a single AXI4 INCR write burst (AW, W beats, B).
// Optional sticky error capture on SLVERR/DECERR responses when DCACHE_WBRIDGE_ERR_EN is defined.
module dcache_axi_wbridge #(
  parameter int         DCACHE_WIDTH   = 128,
  parameter int         AXI_DATA_WIDTH = 32,
  parameter logic [3:0] AXI_ID         = 4'h1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_wen_i,
  input  logic [31:0]                 req_awaddr_i,
  input  logic [DCACHE_WIDTH-1:0]     req_wdata_i,
  output logic                        req_ready_o,
  output logic [3:0]                  m_awid_o,
  output logic [31:0]                 m_awaddr_o,
  output logic [7:0]                  m_awlen_o,
  output logic [2:0]                  m_awsize_o,
  output logic [1:0]                  m_awburst_o,
  output logic                        m_awvalid_o,
  input  logic                        m_awready_i,
  output logic [AXI_DATA_WIDTH-1:0]   m_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0] m_wstrb_o,
  output logic                        m_wlast_o,
  output logic                        m_wvalid_o,
  input  logic                        m_wready_i,
  input  logic [1:0]                  m_bresp_i,
  input  logic                        m_bvalid_i,
  output logic                        m_bready_o,
  output logic                        err_o,
  output logic [31:0]                 err_addr_o
);
  localparam int BEATS  = DCACHE_WIDTH / AXI_DATA_WIDTH;
  localparam int OFFS   = $clog2(DCACHE_WIDTH / 8);
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

  typedef struct packed {
    logic [31:0]                           addr;
    logic [BEATS-1:0][AXI_DATA_WIDTH-1:0]  data;
  } line_t;

  state_t        state;
  line_t         line;
  logic [BW-1:0] beat;

  assign m_awid_o    = AXI_ID;
  assign m_awaddr_o  = line.addr;
  assign m_awlen_o   = 8'(BEATS - 1);
  assign m_awsize_o  = 3'($clog2(STRB_W));
  assign m_awburst_o = 2'b01;
  assign m_wstrb_o   = '1;

  // Every handshake output is a flop; the next beat's data is preloaded on the
  // handshake so W payload never depends combinationally on m_wready_i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      line        <= '0;
      beat        <= '0;
      req_ready_o <= 1'b1;
      m_awvalid_o <= 1'b0;
      m_wvalid_o  <= 1'b0;
      m_wdata_o   <= '0;
      m_wlast_o   <= 1'b0;
      m_bready_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_wen_i) begin
          line.addr   <= {req_awaddr_i[31:OFFS], {OFFS{1'b0}}};
          line.data   <= req_wdata_i;
          req_ready_o <= 1'b0;
          m_awvalid_o <= 1'b1;
          state       <= AW;
        end
        AW: if (m_awready_i) begin
          m_awvalid_o <= 1'b0;
          beat        <= '0;
          m_wvalid_o  <= 1'b1;
          m_wdata_o   <= line.data[0];
          m_wlast_o   <= (BEATS == 1);
          state       <= W;
        end
        W: if (m_wready_i) begin
          if (m_wlast_o) begin
            m_wvalid_o <= 1'b0;
            m_wlast_o  <= 1'b0;
            m_bready_o <= 1'b1;
            state      <= B;
          end else begin
            beat      <= beat + 1'b1;
            m_wdata_o <= line.data[beat + 1'b1];
            m_wlast_o <= ((beat + 1'b1) == LAST_BEAT);
          end
        end
        B: if (m_bvalid_i) begin
          m_bready_o  <= 1'b0;
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_WBRIDGE_ERR_EN
  // First failing burst wins; the flag only clears on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else if (state == B && m_bvalid_i && m_bresp_i[1] && !err_o) begin
      err_o      <= 1'b1;
      err_addr_o <= line.addr;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{req_awaddr_i[OFFS-1:0], m_bresp_i[0]};
`else
  assign err_o      = 1'b0;
  assign err_addr_o = '0;

  logic unused_ok;
  assign unused_ok = ^{req_awaddr_i[OFFS-1:0], m_bresp_i};
`endif

endmodule

// File: tb/tb_dcache_axi_wbridge.sv
// Bench for dcache_axi_wbridge: transaction-level model checked every cycle plus directed literal checks.
module tb_dcache_axi_wbridge;
  localparam int BEATS = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_wen_i = 1'b0;
  logic [31:0]  req_awaddr_i = '0;
  logic [127:0] req_wdata_i = '0;
  logic         req_ready_o;
  logic [3:0]   m_awid_o;
  logic [31:0]  m_awaddr_o;
  logic [7:0]   m_awlen_o;
  logic [2:0]   m_awsize_o;
  logic [1:0]   m_awburst_o;
  logic         m_awvalid_o;
  logic         m_awready_i = 1'b1;
  logic [31:0]  m_wdata_o;
  logic [3:0]   m_wstrb_o;
  logic         m_wlast_o;
  logic         m_wvalid_o;
  logic         m_wready_i = 1'b1;
  logic [1:0]   m_bresp_i = 2'b00;
  logic         m_bvalid_i = 1'b1;
  logic         m_bready_o;
  logic         err_o;
  logic [31:0]  err_addr_o;

  always #5 clk = ~clk;

  dcache_axi_wbridge dut (
    .clk(clk), .rst(rst),
    .req_wen_i(req_wen_i), .req_awaddr_i(req_awaddr_i), .req_wdata_i(req_wdata_i),
    .req_ready_o(req_ready_o),
    .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awlen_o(m_awlen_o),
    .m_awsize_o(m_awsize_o), .m_awburst_o(m_awburst_o),
    .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wlast_o(m_wlast_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
    .err_o(err_o), .err_addr_o(err_addr_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding line, AW then BEATS words then B.
  bit           busy = 0, aw_done = 0, rdy_seen = 0, m_err = 0;
  int           nbeat = 0, cyc = 0, acc_cyc = -1, lat = 0;
  int           acc_cnt = 0, w_cnt = 0, wlast_cnt = 0, wlast_beat = -1, b_cnt = 0, aw_stall = 0;
  logic [31:0]  cur_addr = '0, m_err_addr = '0;
  logic [127:0] cur_data = '0;
  logic [31:0]  aw_addr_q[$];
  logic [31:0]  w_q[$];
  int           ev_q[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      busy = 0; aw_done = 0; nbeat = 0; m_err = 0; m_err_addr = '0; acc_cyc = -1;
      chk("rst_awvalid", m_awvalid_o, 1'b0);
      chk("rst_wvalid", m_wvalid_o, 1'b0);
      chk("rst_bready", m_bready_o, 1'b0);
      chk("rst_err", err_o, 1'b0);
    end else begin
      if (acc_cyc >= 0 && !rdy_seen && req_ready_o) begin
        lat = cyc - acc_cyc;
        rdy_seen = 1;
      end
      chk("req_ready", req_ready_o, !busy);
      chk("awvalid", m_awvalid_o, busy && !aw_done);
      chk("wvalid", m_wvalid_o, busy && aw_done && nbeat < BEATS);
      chk("bready", m_bready_o, busy && aw_done && nbeat == BEATS);
      chk("err_o", err_o, m_err);
      chk("err_addr", err_addr_o, m_err_addr);
      if (busy && !aw_done) begin
        chk("awaddr", m_awaddr_o, cur_addr);
        chk("awid", m_awid_o, 4'h1);
        chk("awlen", m_awlen_o, 8'(BEATS - 1));
        chk("awsize", m_awsize_o, 3'd2);
        chk("awburst", m_awburst_o, 2'b01);
      end
      if (busy && aw_done && nbeat < BEATS) begin
        chk("wdata", m_wdata_o, cur_data[nbeat*32 +: 32]);
        chk("wlast", m_wlast_o, nbeat == BEATS - 1);
        chk("wstrb", m_wstrb_o, 4'hf);
      end
      // the handshakes seen here complete at the coming posedge
      if (!busy) begin
        if (req_wen_i) begin
          busy = 1; aw_done = 0; nbeat = 0;
          cur_addr = {req_awaddr_i[31:4], 4'h0};
          cur_data = req_wdata_i;
          acc_cnt++; acc_cyc = cyc; rdy_seen = 0;
        end
      end else if (!aw_done) begin
        if (m_awready_i) begin
          aw_done = 1; aw_addr_q.push_back(m_awaddr_o); ev_q.push_back(1);
        end else aw_stall++;
      end else if (nbeat < BEATS) begin
        if (m_wready_i) begin
          w_q.push_back(m_wdata_o);
          if (m_wlast_o) begin wlast_cnt++; wlast_beat = nbeat; end
          nbeat++; w_cnt++;
        end
      end else if (m_bvalid_i) begin
        busy = 0; b_cnt++; ev_q.push_back(2);
`ifdef DCACHE_WBRIDGE_ERR_EN
        if (m_bresp_i[1] && !m_err) begin m_err = 1; m_err_addr = cur_addr; end
`endif
      end
    end
  end

  // Present one line, drive readies until its B handshake, then settle one cycle.
  task automatic run_line(input logic [31:0] a, input logic [127:0] d, input logic [1:0] br,
                          input int aw_hold, input bit w_tog);
    int b0, a0, n;
    @(posedge clk); #1;
    b0 = b_cnt; a0 = acc_cnt; n = 0;
    req_awaddr_i = a; req_wdata_i = d; m_bresp_i = br; req_wen_i = 1'b1;
    m_awready_i = (aw_hold == 0); m_wready_i = 1'b1;
    while (b_cnt == b0 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (acc_cnt != a0) req_wen_i = 1'b0;
      m_awready_i = (aw_hold == 0) || (n > aw_hold);
      m_wready_i  = w_tog ? ~m_wready_i : 1'b1;
    end
    chk("line_timeout", n < 200, 1'b1);
    req_wen_i = 1'b0; m_awready_i = 1'b1; m_wready_i = 1'b1; m_bresp_i = 2'b00;
    @(negedge clk); #1;
  endtask

  logic [31:0] sw_words [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  initial begin
    int w0, a0, e0, wl0, b0, c0, n, s0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk); #1;
    chk("boot_ready", req_ready_o, 1'b1);
    chk("boot_awvalid", m_awvalid_o, 1'b0);
    chk("boot_wvalid", m_wvalid_o, 1'b0);
    chk("boot_err", err_o, 1'b0);

    // single line, all readies high
    w0 = w_q.size(); a0 = aw_addr_q.size(); wl0 = wlast_cnt;
    run_line(32'h1C00_0034, 128'h44444444_33333333_22222222_11111111, 2'b00, 0, 1'b0);
    chk("sw_awaddr", aw_addr_q[a0], 32'h1C00_0030);
    chk("sw_awlen", m_awlen_o, 8'd3);
    chk("sw_awsize", m_awsize_o, 3'd2);
    chk("sw_awburst", m_awburst_o, 2'b01);
    chk("sw_nbeats", w_q.size() - w0, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("sw_beat%0d", i), w_q[w0 + i], sw_words[i]);
    chk("sw_wlast_cnt", wlast_cnt - wl0, 1);
    chk("sw_wlast_beat", wlast_beat, 3);
    chk("sw_latency", lat, 7);

    // AW held off 5 cycles, W ready toggling
    c0 = w_cnt; wl0 = wlast_cnt; s0 = aw_stall;
    run_line(32'h2000_0047, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 2'b00, 5, 1'b1);
    chk("bp_aw_stalls", aw_stall - s0, 5);
    chk("bp_w_handshakes", w_cnt - c0, 4);
    chk("bp_wlast_cnt", wlast_cnt - wl0, 1);

    // req_wen_i held high across two lines
    a0 = aw_addr_q.size(); e0 = ev_q.size(); b0 = b_cnt; c0 = acc_cnt; n = 0;
    @(posedge clk); #1;
    req_awaddr_i = 32'h100; req_wdata_i = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0; req_wen_i = 1'b1;
    while (b_cnt < b0 + 2 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (acc_cnt == c0 + 1) begin
        req_awaddr_i = 32'h200; req_wdata_i = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
      end else if (acc_cnt >= c0 + 2) req_wen_i = 1'b0;
    end
    req_wen_i = 1'b0;
    chk("b2b_timeout", n < 200, 1'b1);
    @(negedge clk); #1;
    chk("b2b_accepts", acc_cnt - c0, 2);
    chk("b2b_aw0", aw_addr_q[a0], 32'h100);
    chk("b2b_aw1", aw_addr_q[a0 + 1], 32'h200);
    chk("b2b_ev0", ev_q[e0], 1);
    chk("b2b_ev1", ev_q[e0 + 1], 2);
    chk("b2b_ev2", ev_q[e0 + 2], 1);
    chk("b2b_ev3", ev_q[e0 + 3], 2);

    // error responses
    chk("pre_err", err_o, 1'b0);
    run_line(32'h80, 128'h1, 2'b10, 0, 1'b0);
`ifdef DCACHE_WBRIDGE_ERR_EN
    chk("err_set", err_o, 1'b1);
    chk("err_addr_first", err_addr_o, 32'h80);
`else
    chk("err_off", err_o, 1'b0);
    chk("err_addr_off", err_addr_o, 32'h0);
`endif
    run_line(32'h90, 128'h2, 2'b11, 0, 1'b0);
`ifdef DCACHE_WBRIDGE_ERR_EN
    chk("err_sticky", err_o, 1'b1);
    chk("err_addr_kept", err_addr_o, 32'h80);
`else
    chk("err_off2", err_o, 1'b0);
`endif
    chk("ready_after_err", req_ready_o, 1'b1);

    // asynchronous reset while beat 2 is on the bus
    @(posedge clk); #1;
    b0 = b_cnt; c0 = acc_cnt; n = 0;
    req_awaddr_i = 32'h300; req_wdata_i = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0; req_wen_i = 1'b1;
    while (!(busy && aw_done && nbeat == 2) && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (acc_cnt != c0) req_wen_i = 1'b0;
    end
    req_wen_i = 1'b0;
    chk("mid_timeout", n < 50, 1'b1);
    chk("mid_beat2_data", m_wdata_o, 32'hC2C2C2C2);
    #1 rst = 1'b0;
    #1;
    chk("async_wvalid", m_wvalid_o, 1'b0);
    chk("async_wlast", m_wlast_o, 1'b0);
    chk("async_awvalid", m_awvalid_o, 1'b0);
    chk("async_bready", m_bready_o, 1'b0);
    chk("async_err", err_o, 1'b0);
    chk("async_err_addr", err_addr_o, 32'h0);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_ready", req_ready_o, 1'b1);
    chk("abandoned_no_b", b_cnt - b0, 0);
    b0 = b_cnt; w0 = w_q.size();
    run_line(32'h0000_0040, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0, 2'b00, 0, 1'b0);
    chk("recover_b", b_cnt - b0, 1);
    chk("recover_beat0", w_q[w0], 32'hD0D0D0D0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
